imem_fetch_responder: RTL and testbench
=======================================

Name: imem_fetch_responder

Overview:
- Responder end of the instruction-fetch handshake driven by the program counter.
- Accepts a word-aligned instruction address plus a fetch enable from the PC side.
- Performs the read on a variable-latency instruction-memory bus, then returns the instruction word with a single-cycle iready pulse that lets the PC advance.
- Detects misaligned addresses and bus timeouts and reports both as errors.

Parameters:
- TIMEOUT, 16, cycles in BUSY without mem_ack before the fetch is aborted (legal range 1..255).
- NOP_WORD, 32'h00000013, instruction returned on any error (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state on rising edge
- RST  input  1  synchronous, active-high reset
- iren  input  1  fetch request from datapath; level-sensitive
- PCaddr  input  32  instruction address from PC
- iready  output  1  one-cycle pulse: instr/ierr valid this cycle
- instr  output  32  fetched instruction; held until next response
- ierr  output  1  qualifies iready: 1 = misaligned or timeout
- mem_ren  output  1  bus read request, held until mem_ack or abort
- mem_addr  output  32  bus address; the latched request address
- mem_rdata  input  32  bus read data, valid with mem_ack
- mem_ack  input  1  bus completion, one cycle

Behaviour:
- Reset (RST sampled high at clk edge): state=IDLE; iready=0, instr=0, ierr=0, mem_ren=0, mem_addr=0, timeout counter=0. Reset mid-fetch drops mem_ren on the next edge. A late mem_ack in IDLE is ignored.
- States: IDLE, BUSY, RESP.
- IDLE, iren=0: remain in IDLE.
- IDLE, iren=1, PCaddr[1:0]==0: latch PCaddr into req_addr and mem_addr, clear the counter, go to BUSY.
- IDLE, iren=1, PCaddr[1:0]!=0: no bus request; instr<=NOP_WORD, ierr<=1, go to RESP.
- BUSY: mem_ren=1.
  - mem_ack=1: instr<=mem_rdata, ierr<=0, go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: mem_ren deasserts, instr<=NOP_WORD, ierr<=1, go to RESP.
  - Otherwise the counter increments.
  - mem_ack wins over timeout in the same cycle.
- Address change in BUSY (PCaddr!=req_addr or iren=0): the bus transaction still completes or times out, but no response is presented. State returns to IDLE, iready stays 0, and instr/ierr are unchanged. The datapath refetches.
- RESP: iready=1 for exactly one cycle, then IDLE. A new request is accepted from IDLE on the following edge, so back-to-back fetches cost at least 3 cycles.
- Latency: iren sampled at edge N; mem_ren high in cycle N+1; with mem_ack in that cycle, iready is high in cycle N+2.
- Counter width is 8 bits; it never wraps because the abort happens first.
- Outputs are registered except iready and mem_ren, which are decoded from state.

Optional Feature:
- Macro: IFETCH_BUF_EN.
- Defined: adds a one-entry buffer {valid, addr, data}, loaded on every successful (ierr=0) bus response.
  - On a hit (IDLE, iren=1, aligned, valid=1, PCaddr==buf addr): go straight to RESP with instr<=buf data and no mem_ren. Latency is 1 cycle to iready.
  - valid clears on RST and on any error response.
- Undefined: no buffer; every aligned fetch goes to the bus. Behaviour is identical otherwise.

Test Plan:
- Reset then basic fetch: RST=1 for 2 cycles, then iren=1, PCaddr=0x100, mem_ack after 1 cycle with mem_rdata=0x00500093. Required: mem_addr=0x100; iready high for 1 cycle at edge+2; instr=0x00500093; ierr=0.
- Slow bus: mem_ack after 5 cycles with rdata=0xDEADBEEF. Required: mem_ren high for exactly 5 cycles; iready once; instr=0xDEADBEEF.
- Timeout: TIMEOUT=16 with no mem_ack. Required: mem_ren drops after 16 cycles; iready=1, ierr=1, instr=0x00000013; a later stray mem_ack is ignored.
- Misaligned address: PCaddr=0x102. Required: no mem_ren; iready the next cycle with ierr=1, instr=0x00000013.
- Mid-fetch abort: PCaddr changes 0x100->0x200 while in BUSY, then ack. Required: no iready for 0x100; a new fetch is issued with mem_addr=0x200.
- IFETCH_BUF_EN refetch: fetch 0x100 twice. Required: the second fetch has no mem_ren and iready 1 cycle after iren; with the macro undefined, the second fetch goes to the bus.

Source files
------------

// File: rtl/imem_fetch_responder_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder_if
//
// Groups the two handshakes around the instruction-fetch responder:
//   - PC-side fetch handshake : iren, PCaddr -> iready, instr, ierr
//   - instruction-memory bus  : mem_ren, mem_addr -> mem_rdata, mem_ack
//
// Modports:
//   slave  : the responder (consumes fetch requests, drives the bus request)
//   master : the environment around it (PC datapath plus instruction memory)
// ---------------------------------------------------------------------------
interface imem_fetch_responder_if;
  logic        iren;
  logic [31:0] PCaddr;
  logic        iready;
  logic [31:0] instr;
  logic        ierr;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  iren, PCaddr, mem_rdata, mem_ack,
    output iready, instr, ierr, mem_ren, mem_addr
  );

  modport master (
    output iren, PCaddr, mem_rdata, mem_ack,
    input  iready, instr, ierr, mem_ren, mem_addr
  );
endinterface

// File: rtl/imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder
//
// Responder end of the instruction-fetch handshake. Takes a word-aligned
// address plus a level-sensitive fetch enable from the PC, performs the read
// on a variable-latency instruction-memory bus and returns the word with a
// single-cycle iready pulse. Misaligned addresses and bus timeouts return
// NOP_WORD with ierr=1.
//
// Ports:
//   clk  : system clock, all state updates on the rising edge
//   RST  : synchronous active-high reset
//   bus  : imem_fetch_responder_if.slave
//          iren/PCaddr in, iready/instr/ierr out (fetch handshake)
//          mem_ren/mem_addr out, mem_rdata/mem_ack in (memory bus)
//
// Parameters:
//   TIMEOUT  : BUSY cycles without mem_ack before the fetch is aborted (1..255)
//   NOP_WORD : instruction returned on any error
//
// Optional feature (macro IFETCH_BUF_EN): one-entry {valid, addr, data}
// buffer loaded on every good bus response; a matching aligned fetch is
// answered from the buffer without a bus access.
// ---------------------------------------------------------------------------
module imem_fetch_responder #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input logic                   clk,
  input logic                   RST,
  imem_fetch_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [31:0] instr_q, instr_n;
  logic        ierr_q, ierr_n;
  logic [31:0] req_addr, req_addr_n;
  logic [7:0]  cnt, cnt_n;
  // Set once the PC has moved away from the in-flight address; the bus
  // transaction is still finished, but its result is thrown away.
  logic        stale, stale_n;
  logic        addr_changed;
  logic        drop;

`ifdef IFETCH_BUF_EN
  logic        buf_valid, buf_valid_n;
  logic [31:0] buf_addr, buf_addr_n;
  logic [31:0] buf_data, buf_data_n;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state    <= IDLE;
      instr_q  <= '0;
      ierr_q   <= 1'b0;
      req_addr <= '0;
      cnt      <= '0;
      stale    <= 1'b0;
`ifdef IFETCH_BUF_EN
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
`endif
    end else begin
      state    <= state_n;
      instr_q  <= instr_n;
      ierr_q   <= ierr_n;
      req_addr <= req_addr_n;
      cnt      <= cnt_n;
      stale    <= stale_n;
`ifdef IFETCH_BUF_EN
      buf_valid <= buf_valid_n;
      buf_addr  <= buf_addr_n;
      buf_data  <= buf_data_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    instr_n      = instr_q;
    ierr_n       = ierr_q;
    req_addr_n   = req_addr;
    cnt_n        = cnt;
    stale_n      = stale;
    addr_changed = 1'b0;
    drop         = 1'b0;
`ifdef IFETCH_BUF_EN
    buf_valid_n = buf_valid;
    buf_addr_n  = buf_addr;
    buf_data_n  = buf_data;
`endif

    case (state)
      IDLE: begin
        if (bus.iren) begin
          if (bus.PCaddr[1:0] != 2'b00) begin
            instr_n = NOP_WORD;
            ierr_n  = 1'b1;
            state_n = RESP;
`ifdef IFETCH_BUF_EN
            buf_valid_n = 1'b0;
`endif
          end
`ifdef IFETCH_BUF_EN
          else if (buf_valid && (bus.PCaddr == buf_addr)) begin
            instr_n = buf_data;
            ierr_n  = 1'b0;
            state_n = RESP;
          end
`endif
          else begin
            req_addr_n = bus.PCaddr;
            cnt_n      = '0;
            stale_n    = 1'b0;
            state_n    = BUSY;
          end
        end
      end

      BUSY: begin
        addr_changed = !bus.iren || (bus.PCaddr != req_addr);
        drop         = stale || addr_changed;
        // An ack in the final counted cycle still wins over the abort.
        if (bus.mem_ack) begin
          if (drop) begin
            state_n = IDLE;
          end else begin
            instr_n = bus.mem_rdata;
            ierr_n  = 1'b0;
            state_n = RESP;
`ifdef IFETCH_BUF_EN
            buf_valid_n = 1'b1;
            buf_addr_n  = req_addr;
            buf_data_n  = bus.mem_rdata;
`endif
          end
        end else if (cnt == LAST_COUNT) begin
          if (drop) begin
            state_n = IDLE;
          end else begin
            instr_n = NOP_WORD;
            ierr_n  = 1'b1;
            state_n = RESP;
`ifdef IFETCH_BUF_EN
            buf_valid_n = 1'b0;
`endif
          end
        end else begin
          cnt_n   = cnt + 8'd1;
          stale_n = drop;
        end
      end

      RESP: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  assign bus.iready   = (state == RESP);
  assign bus.mem_ren  = (state == BUSY);
  assign bus.instr    = instr_q;
  assign bus.ierr     = ierr_q;
  assign bus.mem_addr = req_addr;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_responder
//
// Self-checking bench for imem_fetch_responder. Drives the PC and memory
// sides through the interface and compares against a transaction-level
// model of the fetch rules (latency, bus occupancy, returned word, error).
// ---------------------------------------------------------------------------
module tb_imem_fetch_responder;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
`ifdef IFETCH_BUF_EN
  localparam bit BUF_ON = 1'b1;
`else
  localparam bit BUF_ON = 1'b0;
`endif

  logic clk;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  imem_fetch_responder_if bus ();

  imem_fetch_responder #(
    .TIMEOUT  (TIMEOUT),
    .NOP_WORD (NOP_WORD)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model state
  logic        m_buf_valid = 1'b0;
  logic [31:0] m_buf_addr  = '0;
  logic [31:0] m_buf_data  = '0;
  logic [31:0] m_last_instr = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Outcome of one fetch from the PC's point of view.
  task automatic modelFetch(input logic [31:0] addr, input int delay,
                            input logic [31:0] rdata,
                            output int exp_ren, output int exp_lat,
                            output logic [31:0] exp_instr, output logic exp_err);
    if (addr[1:0] != 2'b00) begin
      exp_ren = 0; exp_lat = 1; exp_instr = NOP_WORD; exp_err = 1'b1;
      m_buf_valid = 1'b0;
    end else if (BUF_ON && m_buf_valid && addr == m_buf_addr) begin
      exp_ren = 0; exp_lat = 1; exp_instr = m_buf_data; exp_err = 1'b0;
    end else if (delay <= TIMEOUT) begin
      exp_ren = delay; exp_lat = delay + 1; exp_instr = rdata; exp_err = 1'b0;
      m_buf_valid = 1'b1; m_buf_addr = addr; m_buf_data = rdata;
    end else begin
      exp_ren = TIMEOUT; exp_lat = TIMEOUT + 1; exp_instr = NOP_WORD; exp_err = 1'b1;
      m_buf_valid = 1'b0;
    end
    m_last_instr = exp_instr;
  endtask

  // Hold iren/PCaddr, ack the bus on the delay-th mem_ren cycle, and record
  // what the responder presented. Bounded so a missing iready cannot hang.
  task automatic applyStimulus(input logic [31:0] addr, input int delay,
                               input logic [31:0] rdata,
                               output int ren_cycles, output int resp_lat,
                               output logic [31:0] got_instr, output logic got_err,
                               output logic [31:0] got_addr);
    ren_cycles = 0; resp_lat = -1; got_instr = 'x; got_err = 1'bx; got_addr = '0;
    @(negedge clk);
    bus.iren = 1'b1; bus.PCaddr = addr; bus.mem_ack = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_ren) begin
        ren_cycles++;
        got_addr = bus.mem_addr;
        if (ren_cycles == delay) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
        end
      end
      if (bus.iready) begin
        resp_lat = c; got_instr = bus.instr; got_err = bus.ierr;
        break;
      end
    end
    bus.iren = 1'b0; bus.mem_ack = 1'b0;
  endtask

  task automatic runFetch(input string tag, input logic [31:0] addr,
                          input int delay, input logic [31:0] rdata);
    int e_ren, e_lat, g_ren, g_lat;
    logic [31:0] e_instr, g_instr, g_addr;
    logic e_err, g_err;
    modelFetch(addr, delay, rdata, e_ren, e_lat, e_instr, e_err);
    applyStimulus(addr, delay, rdata, g_ren, g_lat, g_instr, g_err, g_addr);
    checkOutput({tag, ".ren_cycles"}, 32'(g_ren), 32'(e_ren));
    checkOutput({tag, ".latency"}, 32'(g_lat), 32'(e_lat));
    checkOutput({tag, ".instr"}, g_instr, e_instr);
    checkOutput({tag, ".ierr"}, {31'd0, g_err}, {31'd0, e_err});
    if (e_ren > 0) checkOutput({tag, ".mem_addr"}, g_addr, addr);
    @(negedge clk);
    checkOutput({tag, ".iready_single"}, {31'd0, bus.iready}, 32'd0);
  endtask

  initial begin
    logic        early_ready;
    logic        second_issued;
    logic [31:0] second_addr;
    logic [31:0] instr_after_drop;
    logic [31:0] pool [5];
    int          resp_seen;
    logic [31:0] r_instr;
    logic        r_err;

    bus.iren = 1'b0; bus.PCaddr = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
    RST = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset.iready", {31'd0, bus.iready}, 32'd0);
    checkOutput("reset.instr", bus.instr, 32'd0);
    checkOutput("reset.ierr", {31'd0, bus.ierr}, 32'd0);
    checkOutput("reset.mem_ren", {31'd0, bus.mem_ren}, 32'd0);
    checkOutput("reset.mem_addr", bus.mem_addr, 32'd0);
    RST = 1'b0;

    runFetch("basic", 32'h100, 1, 32'h0050_0093);
    runFetch("slow", 32'h104, 5, 32'hDEAD_BEEF);
    runFetch("timeout", 32'h108, 1000, 32'h1111_1111);

    // Stray ack after the abort must not produce a response.
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checkOutput("stray.iready", {31'd0, bus.iready}, 32'd0);
    @(negedge clk);
    checkOutput("stray.iready2", {31'd0, bus.iready}, 32'd0);
    checkOutput("stray.instr", bus.instr, NOP_WORD);
    checkOutput("stray.mem_ren", {31'd0, bus.mem_ren}, 32'd0);

    runFetch("misaligned", 32'h102, 1, 32'h2222_2222);

    // PC moves from 0x100 to 0x200 mid-fetch: old result discarded, refetch.
    early_ready = 1'b0; second_issued = 1'b0; second_addr = '0;
    instr_after_drop = 'x; resp_seen = 0; r_instr = 'x; r_err = 1'bx;
    @(negedge clk);
    bus.iren = 1'b1; bus.PCaddr = 32'h100;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.iready) begin
        if (!second_issued) early_ready = 1'b1;
        else begin
          resp_seen = c; r_instr = bus.instr; r_err = bus.ierr;
          break;
        end
      end
      if (c == 2) bus.PCaddr = 32'h200;
      if (c == 4) instr_after_drop = bus.instr;
      if (bus.mem_ren && c == 3) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h3333_3333;
      end else if (bus.mem_ren && c > 4) begin
        second_issued = 1'b1; second_addr = bus.mem_addr;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0293;
      end
    end
    bus.iren = 1'b0; bus.mem_ack = 1'b0;
    checkOutput("abort.no_ready", {31'd0, early_ready}, 32'd0);
    checkOutput("abort.instr_kept", instr_after_drop, m_last_instr);
    checkOutput("abort.refetch_addr", second_addr, 32'h200);
    checkOutput("abort.resp_cycle", 32'(resp_seen), 32'd6);
    checkOutput("abort.instr", r_instr, 32'h0000_0293);
    checkOutput("abort.ierr", {31'd0, r_err}, 32'd0);
    m_buf_valid = 1'b1; m_buf_addr = 32'h200; m_buf_data = 32'h0000_0293;
    m_last_instr = 32'h0000_0293;
    @(negedge clk);

    runFetch("refetch1", 32'h300, 2, 32'h0070_0113);
    runFetch("refetch2", 32'h300, 2, 32'h0070_0113);

    // Reset during BUSY drops the bus request on the next edge.
    @(negedge clk);
    bus.iren = 1'b1; bus.PCaddr = 32'h400;
    repeat (2) @(negedge clk);
    checkOutput("rstmid.busy", {31'd0, bus.mem_ren}, 32'd1);
    RST = 1'b1;
    @(negedge clk);
    checkOutput("rstmid.mem_ren", {31'd0, bus.mem_ren}, 32'd0);
    checkOutput("rstmid.instr", bus.instr, 32'd0);
    RST = 1'b0; bus.iren = 1'b0;
    m_buf_valid = 1'b0; m_last_instr = '0;
    @(negedge clk);

    pool[0] = 32'h1000; pool[1] = 32'h1004; pool[2] = 32'h1008;
    pool[3] = 32'h1002; pool[4] = 32'h1003;
    for (int i = 0; i < 24; i++) begin
      runFetch($sformatf("rand%0d", i), pool[$urandom_range(0, 4)],
               int'($urandom_range(1, 20)), $urandom);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
